// File: rtl/if_id_buffer.sv
// IF/ID pipeline buffer: circular FIFO of {pc, instr} pairs between fetch and decode,
// with first-word fall-through to decode, flush-on-redirect and a saturating flush counter.
module if_id_buffer #(
    parameter int          DEPTH     = 2,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       fetch_valid,
    input  logic [31:0]                fetch_pc,
    input  logic [31:0]                fetch_instr,
    output logic                       fetch_ready,
    input  logic                       flush,
    output logic                       id_valid,
    output logic [31:0]                id_pc,
    output logic [31:0]                id_instr,
    input  logic                       id_ready,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic [15:0]                flush_count
);

    localparam int                PTR_W   = $clog2(DEPTH);
    localparam int                CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);

    logic [31:0]      pc_mem    [DEPTH];
    logic [31:0]      instr_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] occ_q, occ_d;
    logic [15:0]      flush_cnt_q, flush_cnt_d;

    logic             fetch_ready_s;
    logic             id_valid_s;
    logic             push_s;
    logic             pop_s;

    // Handshake status depends on registered occupancy only.
    always_comb begin
        fetch_ready_s = (occ_q < DEPTH_C);
        id_valid_s    = (occ_q != {CNT_W{1'b0}});
        push_s        = fetch_valid && fetch_ready_s && !flush;
        pop_s         = id_valid_s && id_ready && !flush;
    end

    // Next-state for pointers, occupancy and flush counter; flush overrides push/pop.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        occ_d       = occ_q;
        flush_cnt_d = flush_cnt_q;
        if (flush) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            occ_d    = {CNT_W{1'b0}};
            if (flush_cnt_q != 16'hFFFF) begin
                flush_cnt_d = flush_cnt_q + 16'd1;
            end else begin
                flush_cnt_d = flush_cnt_q;
            end
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   occ_d = occ_q + CNT_W'(1);
                2'b01:   occ_d = occ_q - CNT_W'(1);
                default: occ_d = occ_q;
            endcase
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= {PTR_W{1'b0}};
            rd_ptr_q    <= {PTR_W{1'b0}};
            occ_q       <= {CNT_W{1'b0}};
            flush_cnt_q <= 16'h0000;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Entry storage is never reset; only entries counted by occupancy are ever read out.
    always_ff @(posedge clk) begin
        if (push_s && !reset) begin
            pc_mem[wr_ptr_q]    <= fetch_pc;
            instr_mem[wr_ptr_q] <= fetch_instr;
        end
    end

    // Head entry falls through to decode; an empty buffer presents pc 0 and a NOP.
    always_comb begin
        if (id_valid_s) begin
            id_pc    = pc_mem[rd_ptr_q];
            id_instr = instr_mem[rd_ptr_q];
        end else begin
            id_pc    = 32'h0000_0000;
            id_instr = NOP_INSTR;
        end
    end

    assign fetch_ready = fetch_ready_s;
    assign id_valid    = id_valid_s;
    assign occupancy   = occ_q;
    assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_if_id_buffer.sv
// Self-checking bench for if_id_buffer: directed scenarios plus random traffic,
// compared against a queue-based reference model of the buffer.
module tb_if_id_buffer;

    localparam int          DEPTH = 2;
    localparam int          CW    = $clog2(DEPTH) + 1;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic          clk = 1'b0;
    logic          reset, fetch_valid, flush, id_ready;
    logic [31:0]   fetch_pc, fetch_instr;
    logic          fetch_ready, id_valid;
    logic [31:0]   id_pc, id_instr;
    logic [CW-1:0] occupancy;
    logic [15:0]   flush_count;

    if_id_buffer #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
        .clk(clk), .reset(reset),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_instr(fetch_instr),
        .fetch_ready(fetch_ready), .flush(flush),
        .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr), .id_ready(id_ready),
        .occupancy(occupancy), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [31:0] pc; logic [31:0] instr; } ent_t;
    ent_t q[$];
    int   fc;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, then compare everything.
    task automatic cyc(input logic fv, input logic [31:0] pc, input logic [31:0] ins,
                       input logic idr, input logic fl, input logic rs);
        bit   do_push, do_pop;
        ent_t e;
        @(negedge clk);
        fetch_valid = fv; fetch_pc = pc; fetch_instr = ins;
        id_ready = idr; flush = fl; reset = rs;
        do_push = fv && (q.size() < DEPTH);
        do_pop  = idr && (q.size() > 0);
        @(posedge clk);
        if (rs) begin
            q.delete();
            fc = 0;
        end else if (fl) begin
            q.delete();
            if (fc < 65535) fc++;
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                e.pc = pc; e.instr = ins;
                q.push_back(e);
            end
        end
        #1;
        chk("occupancy",   64'(occupancy),   64'(q.size()));
        chk("id_valid",    64'(id_valid),    64'(q.size() != 0));
        chk("fetch_ready", 64'(fetch_ready), 64'(q.size() < DEPTH));
        chk("id_pc",       64'(id_pc),       (q.size() != 0) ? 64'(q[0].pc) : 64'h0);
        chk("id_instr",    64'(id_instr),    (q.size() != 0) ? 64'(q[0].instr) : 64'(NOP));
        chk("flush_count", 64'(flush_count), 64'(fc));
    endtask

    initial begin
        fetch_valid = 1'b0; fetch_pc = 32'h0; fetch_instr = 32'h0;
        id_ready = 1'b0; flush = 1'b0; reset = 1'b1;
        fc = 0;

        // Reset state
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("rst_fetch_ready", 64'(fetch_ready), 64'd1);
        chk("rst_id_instr",    64'(id_instr),    64'(NOP));

        // First push visible next cycle
        cyc(1'b1, 32'h0, 32'h00500093, 1'b0, 1'b0, 1'b0);
        chk("push1_pc",    64'(id_pc),    64'h0);
        chk("push1_instr", 64'(id_instr), 64'h00500093);
        chk("push1_occ",   64'(occupancy), 64'd1);

        // Fill to full; third pair refused
        cyc(1'b1, 32'h4, 32'h00400113, 1'b0, 1'b0, 1'b0);
        chk("full_ready", 64'(fetch_ready), 64'd0);
        cyc(1'b1, 32'h8, 32'h00800193, 1'b0, 1'b0, 1'b0);
        chk("full_occ", 64'(occupancy), 64'd2);
        chk("full_head", 64'(id_pc), 64'h0);

        // Single pop from full
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("pop_ready", 64'(fetch_ready), 64'd1);
        chk("pop_head",  64'(id_pc), 64'h4);

        // Streaming push/pop with pointer wrap
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 32'h8 + 32'(4 * i), 32'hA000_0000 + 32'(i), 1'b1, 1'b0, 1'b0);
            chk("stream_pc", 64'(id_pc), 64'(32'h8 + 32'(4 * i)));
        end

        // Flush with a concurrent push and pop from full
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 32'h10, 32'h11, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h14, 32'h15, 1'b0, 1'b0, 1'b0);
        chk("preflush_occ", 64'(occupancy), 64'd2);
        cyc(1'b1, 32'h100, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0);
        chk("flush_occ",   64'(occupancy), 64'd0);
        chk("flush_instr", 64'(id_instr), 64'h13);
        chk("flush_cnt",   64'(flush_count), 64'd1);
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("flush_drop", 64'(id_valid), 64'd0);

        // Push into empty with id_ready high must not pop
        cyc(1'b1, 32'h20, 32'h21, 1'b1, 1'b0, 1'b0);
        chk("empty_pushpop_occ", 64'(occupancy), 64'd1);

        // Long flush saturates the counter
        for (int i = 0; i < 70000; i++) cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("flush_sat", 64'(flush_count), 64'hFFFF);

        // Reset mid-stream with two entries buffered
        cyc(1'b1, 32'h30, 32'h31, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h34, 32'h35, 1'b0, 1'b0, 1'b0);
        chk("prerst_occ", 64'(occupancy), 64'd2);
        cyc(1'b1, 32'h38, 32'h39, 1'b1, 1'b1, 1'b1);
        chk("midrst_occ",   64'(occupancy),   64'd0);
        chk("midrst_fc",    64'(flush_count), 64'd0);
        chk("midrst_ready", 64'(fetch_ready), 64'd1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 3) != 0), $urandom, $urandom,
                ($urandom_range(0, 4) < 3), ($urandom_range(0, 19) == 0),
                ($urandom_range(0, 99) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/if_id_buffer.md
IF_ID_BUFFER -- requirements
Module: if_id_buffer

Interface
REQ-001: Parameter DEPTH, default 2, number of instruction entries; SHALL be a power of two, >= 2.
REQ-002: Parameter NOP_INSTR, default 32'h00000013, instruction word driven to decode when empty.
REQ-003: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004: reset  input  1  synchronous, active-high reset.
REQ-005: fetch_valid  input  1  fetch presents a valid PC/instruction pair this cycle.
REQ-006: fetch_pc  input  32  PC of the presented instruction.
REQ-007: fetch_instr  input  32  instruction word read at fetch_pc.
REQ-008: fetch_ready  output  1  buffer accepts a pair this cycle.
REQ-009: flush  input  1  redirect taken (branch/jump resolved); discard all buffered and incoming entries.
REQ-010: id_valid  output  1  head entry valid for decode.
REQ-011: id_pc  output  32  PC of head entry.
REQ-012: id_instr  output  32  instruction word of head entry.
REQ-013: id_ready  input  1  decode consumes head entry this cycle.
REQ-014: occupancy  output  $clog2(DEPTH)+1  number of valid entries.
REQ-015: flush_count  output  16  saturating count of flush events.

Function
REQ-016: Buffer SHALL be a circular FIFO of DEPTH entries {pc, instr}, read/write pointers $clog2(DEPTH) bits, wrapping DEPTH-1 -> 0.
REQ-017: Push SHALL occur when fetch_valid && fetch_ready && !flush; entry written at write pointer, pointer +1.
REQ-018: Pop SHALL occur when id_valid && id_ready && !flush; read pointer +1.
REQ-019: fetch_ready SHALL equal (occupancy < DEPTH), registered-state only; no combinational path from id_ready or fetch_valid.
REQ-020: id_valid SHALL equal (occupancy != 0); id_pc/id_instr SHALL show head entry combinationally from storage (first-word fall-through, 0-cycle read latency).
REQ-021: When empty, id_pc SHALL be 32'h0 and id_instr SHALL be NOP_INSTR.
REQ-022: Push-to-id_valid latency SHALL be 1 cycle (entry visible the cycle after the push edge).
REQ-023: Simultaneous push and pop with 0 < occupancy < DEPTH SHALL leave occupancy unchanged, both pointers advance.
REQ-024: Push into empty with simultaneous id_ready SHALL not pop (id_valid was 0); occupancy becomes 1.
REQ-025: When full, fetch_ready SHALL be 0; a pop in that cycle SHALL raise fetch_ready the next cycle, not the same cycle.
REQ-026: flush SHALL take priority over push and pop: next cycle occupancy = 0, both pointers = 0, id_valid = 0; pair presented during flush cycle SHALL be dropped.
REQ-027: flush_count SHALL increment by 1 on each cycle flush is high, saturating at 16'hFFFF.
REQ-028: Storage contents of non-valid entries SHALL never be observable on id_pc/id_instr.

Reset
REQ-029: When reset is high at a rising edge, pointers, occupancy and flush_count SHALL become 0; id_valid=0, fetch_ready=1, id_instr=NOP_INSTR, id_pc=0 from the next cycle.
REQ-030: reset SHALL take priority over flush, push and pop; reset mid-stream discards all entries.
REQ-031: Storage arrays SHALL not require reset.

Verification
REQ-032: Reset, then push pc=0x0 instr=0x00500093 with id_ready=0 -> next cycle id_valid=1, id_pc=0x0, id_instr=0x00500093, occupancy=1.
REQ-033: DEPTH=2, id_ready=0, push 0x0,0x4,0x8 on consecutive cycles -> 0x0 and 0x4 accepted, fetch_ready=0 during 0x8, occupancy=2, 0x8 not stored.
REQ-034: Full buffer, id_ready=1 one cycle -> next cycle occupancy=1, fetch_ready=1, id_pc=0x4; continuous push/pop for 10 cycles -> in-order PCs 0x4..0x28 observed, pointers wrap with no loss.
REQ-035: occupancy=2, flush=1 with fetch_valid=1 pc=0x100 and id_ready=1 -> next cycle id_valid=0, occupancy=0, id_instr=0x00000013, flush_count=1; 0x100 never appears.
REQ-036: Hold flush high 70000 cycles -> flush_count stops at 16'hFFFF; assert reset mid-stream with occupancy=2 -> next cycle occupancy=0, flush_count=0, fetch_ready=1.
